mdu_hilo: RTL



---
 rtl/mdu_hilo_if.sv | 28 ++
 rtl/mdu_hilo.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mdu_hilo_if.sv
// EX-stage multiply/divide request and HI/LO write-back bundle.
// ID/EX drives the master side and the MDU is the slave.
interface mdu_hilo_if;
  logic        flush;
  logic        ex_stall;
  logic        inst_mult;
  logic        inst_multu;
  logic        inst_div;
  logic        inst_divu;
  logic        inst_mthi;
  logic        inst_mtlo;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stallreq_mdu;
  logic [65:0] hilo_bus;

  modport master (
    output flush, ex_stall, inst_mult, inst_multu, inst_div, inst_divu,
           inst_mthi, inst_mtlo, src_a, src_b,
    input  stallreq_mdu, hilo_bus
  );

  modport slave (
    input  flush, ex_stall, inst_mult, inst_multu, inst_div, inst_divu,
           inst_mthi, inst_mtlo, src_a, src_b,
    output stallreq_mdu, hilo_bus
  );
endinterface

// File: rtl/mdu_hilo.sv
// Multiply/divide unit: radix-2 restoring divide, single-cycle or iterative
// multiply, and mthi/mtlo pass-through onto the 66-bit HI/LO write bus.
module mdu_hilo #(
  parameter int MUL_ITER = 0
) (
  input logic       clk,
  input logic       rst,
  mdu_hilo_if.slave m
);
  typedef enum logic [1:0] {IDLE, DIV_BUSY, MUL_BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [63:0] sh;      // div: dividend/quotient in [31:0]; mul: shifting multiplicand
  logic [63:0] acc;     // div: partial remainder in [31:0]; mul: product accumulator
  logic [31:0] opb;     // divisor magnitude, or multiplier shifting right
  logic        neg_q, neg_r;
  logic [31:0] res_hi, res_lo;

  logic        is_div, is_mul, signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] a_ext, b_ext, prod1;

  assign is_div    = m.inst_div | m.inst_divu;
  assign is_mul    = m.inst_mult | m.inst_multu;
  assign signed_op = m.inst_div | m.inst_mult;
  assign a_neg     = signed_op & m.src_a[31];
  assign b_neg     = signed_op & m.src_b[31];
  assign a_mag     = a_neg ? -m.src_a : m.src_a;
  assign b_mag     = b_neg ? -m.src_b : m.src_b;
  assign a_ext     = {{32{a_neg | (m.inst_mult & m.src_a[31])}}, m.src_a};
  assign b_ext     = {{32{b_neg | (m.inst_mult & m.src_b[31])}}, m.src_b};
  assign prod1     = a_ext * b_ext;

  // One restoring-divide step and one shift-add step, both off the shared regs
  logic [32:0] shifted, diff;
  logic        q_bit;
  logic [31:0] rem_nx, quo_nx, q_fin, r_fin;
  logic [63:0] acc_m, p_fin;

  assign shifted = {acc[31:0], sh[31]};
  assign diff    = shifted - {1'b0, opb};
  assign q_bit   = ~diff[32];
  assign rem_nx  = q_bit ? diff[31:0] : shifted[31:0];
  assign quo_nx  = {sh[30:0], q_bit};
  assign q_fin   = neg_q ? -quo_nx : quo_nx;
  assign r_fin   = neg_r ? -rem_nx : rem_nx;
  assign acc_m   = opb[0] ? acc + sh : acc;
  assign p_fin   = neg_q ? -acc_m : acc_m;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (is_div)      state_nx = (m.src_b == 32'd0) ? DONE : DIV_BUSY;
        else if (is_mul) state_nx = (MUL_ITER != 0) ? MUL_BUSY : DONE;
      end
      DIV_BUSY: if (cnt == 5'd31) state_nx = DONE;
      MUL_BUSY: if (cnt == 5'd31) state_nx = DONE;
      DONE:     if (!m.ex_stall) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (m.flush) state_nx = IDLE;
  end

  always_comb begin
    m.stallreq_mdu = 1'b0;
    m.hilo_bus     = '0;
    if (!m.flush) begin
      case (state)
        IDLE: begin
          if (is_div | is_mul) m.stallreq_mdu = 1'b1;
          else if (m.inst_mthi) m.hilo_bus = {2'b10, m.src_a, 32'd0};
          else if (m.inst_mtlo) m.hilo_bus = {2'b01, 32'd0, m.src_a};
        end
        DIV_BUSY, MUL_BUSY: m.stallreq_mdu = 1'b1;
        DONE:               m.hilo_bus = {2'b11, res_hi, res_lo};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; sh <= '0; acc <= '0; opb <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; res_hi <= '0; res_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_div) begin
            // divide-by-zero result is preloaded; real quotients overwrite it
            sh <= {32'd0, a_mag}; acc <= '0; opb <= b_mag; cnt <= '0;
            neg_q <= a_neg ^ b_neg; neg_r <= a_neg;
            res_hi <= m.src_a; res_lo <= 32'hFFFF_FFFF;
          end else if (is_mul) begin
            sh <= {32'd0, a_mag}; acc <= '0; opb <= b_mag; cnt <= '0;
            neg_q <= a_neg ^ b_neg;
            {res_hi, res_lo} <= prod1;
          end
        end
        DIV_BUSY: begin
          acc[31:0] <= rem_nx;
          sh[31:0]  <= quo_nx;
          cnt       <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            res_hi <= r_fin;
            res_lo <= q_fin;
          end
        end
        MUL_BUSY: begin
          acc <= acc_m;
          sh  <= {sh[62:0], 1'b0};
          opb <= {1'b0, opb[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) {res_hi, res_lo} <= p_fin;
        end
        default: ;
      endcase
    end
  end
endmodule
